crap_round_ctrl: RTL and testbench

Round sequencer for the dice craps game. It debounces the player button, gates the two dice generators with a roll enable, captures the dice faces and their sum, and applies the craps rules across the come-out roll and the point rolls. It sits between the button pin, the two dice generators and the seven-segment display. It drives the Win/Loose/Press indicators and the displayed sum.

---
 rtl/crap_round_ctrl_if.sv | 13 +
 rtl/crap_round_ctrl.sv | 78 +++++++
 tb/tb_crap_round_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crap_round_ctrl_if.sv
// crap_round_ctrl_if: dice inputs, roll enable, display and indicator signals of the craps round sequencer
interface crap_round_ctrl_if;
  logic [3:0] dice1, dice2, sum, point;
  logic roll_en, sum_valid, point_valid, Press, Win, Loose, dice_err;
  modport master(
    input dice1, dice2,
    output roll_en, sum, sum_valid, point, point_valid, Press, Win, Loose, dice_err
  );
  modport slave(
    output dice1, dice2,
    input roll_en, sum, sum_valid, point, point_valid, Press, Win, Loose, dice_err
  );
endinterface

// File: rtl/crap_round_ctrl.sv
// crap_round_ctrl: debounced-button craps round sequencer driving dice roll enable, sum/point display and Win/Loose/Press
module crap_round_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ROLL_MIN = 8
) (
  input logic clk,
  input logic reset,
  input logic btn,
  crap_round_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, ROLL, LATCH, EVAL, POINT_WAIT, DONE_WIN, DONE_LOSE} state_t;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(ROLL_MIN + 1);
  state_t state, state_n;
  logic s1, s2, btn_db, btn_dq, press, bad, roll_done, win_co, lose_co;
  logic err, sum_v, point_v;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] roll_cnt;
  logic [3:0] sum_q, point_q;
  assign press = btn_db & ~btn_dq;
  assign bad = bus.dice1 == 4'd0 || bus.dice1 > 4'd6 || bus.dice2 == 4'd0 || bus.dice2 > 4'd6;
  assign roll_done = roll_cnt >= RW'(ROLL_MIN - 1);
  assign win_co = sum_q == 4'd7 || sum_q == 4'd11;
  assign lose_co = sum_q == 4'd2 || sum_q == 4'd3 || sum_q == 4'd12;
  always_ff @(posedge clk) state <= !reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, POINT_WAIT, DONE_WIN, DONE_LOSE: state_n = press ? ROLL : state;
      ROLL: state_n = roll_done && !btn_db ? LATCH : ROLL;
      LATCH: state_n = bad ? ROLL : EVAL;
      EVAL: state_n = !point_v ? (win_co ? DONE_WIN : lose_co ? DONE_LOSE : POINT_WAIT)
                               : (sum_q == point_q ? DONE_WIN : sum_q == 4'd7 ? DONE_LOSE : POINT_WAIT);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      btn_db <= 1'b0;
      btn_dq <= 1'b0;
      db_cnt <= '0;
      roll_cnt <= '0;
      err <= 1'b0;
      sum_q <= '0;
      sum_v <= 1'b0;
      point_q <= '0;
      point_v <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      btn_dq <= btn_db;
      if (s2 == btn_db) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt <= '0;
        btn_db <= ~btn_db;
      end else db_cnt <= db_cnt + DW'(1);
      roll_cnt <= state != ROLL ? '0 : roll_cnt == RW'(ROLL_MIN) ? roll_cnt : roll_cnt + RW'(1);
      err <= state == LATCH && bad;
      if (state == LATCH) sum_q <= bus.dice1 + bus.dice2;
      sum_v <= state == LATCH ? ~bad : (state != ROLL && state_n == ROLL) ? 1'b0 : sum_v;
      if (state == EVAL && !point_v && state_n == POINT_WAIT) begin
        point_q <= sum_q;
        point_v <= 1'b1;
      end else if ((state == DONE_WIN || state == DONE_LOSE) && press) point_v <= 1'b0;
    end
  end
  assign bus.roll_en = state == ROLL;
  assign bus.Press = state == IDLE || state == POINT_WAIT;
  assign bus.Win = state == DONE_WIN;
  assign bus.Loose = state == DONE_LOSE;
  assign bus.sum = sum_q;
  assign bus.sum_valid = sum_v;
  assign bus.point = point_q;
  assign bus.point_valid = point_v;
  assign bus.dice_err = err;
endmodule

// File: tb/tb_crap_round_ctrl.sv
// tb_crap_round_ctrl: directed and randomized checks of crap_round_ctrl against a round-level model
module tb_crap_round_ctrl;
  localparam int DEB = 4;
  localparam int RMIN = 8;
  logic clk, reset, btn;
  crap_round_ctrl_if bus();
  crap_round_ctrl #(.DEBOUNCE_CYCLES(DEB), .ROLL_MIN(RMIN)) dut(.clk(clk), .reset(reset), .btn(btn), .bus(bus));
  typedef enum {M_WAIT, M_SPIN, M_GRAB, M_SHOW, M_WON, M_LOST} phase_t;
  phase_t ph;
  int vectors, miscompares, rolls;
  int spin, run, m_sum, m_point;
  bit chk_en, m_sv, m_pv, m_err, db, db_last;
  bit [1:0] syn;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic int craps(bit comeout, int pt, int s);
    if (comeout) return (s == 7 || s == 11) ? 0 : (s == 2 || s == 3 || s == 12) ? 1 : 2;
    return s == pt ? 0 : s == 7 ? 1 : 2;
  endfunction
  function automatic logic [3:0] rnd_face();
    return ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
  endfunction
  always @(posedge clk) begin
    if (!reset) begin
      ph = M_WAIT;
      spin = 0;
      run = 0;
      m_sum = 0;
      m_point = 0;
      m_sv = 0;
      m_pv = 0;
      m_err = 0;
      db = 0;
      db_last = 0;
      syn = 0;
    end else begin
      m_err = 0;
      case (ph)
        M_WAIT, M_WON, M_LOST: if (db && !db_last) begin
          if (ph != M_WAIT) m_pv = 0;
          ph = M_SPIN;
          spin = 0;
          m_sv = 0;
        end
        M_SPIN: begin
          spin++;
          if (spin >= RMIN && !db) ph = M_GRAB;
        end
        M_GRAB: begin
          m_sum = (int'(bus.dice1) + int'(bus.dice2)) % 16;
          if (bus.dice1 inside {[1:6]} && bus.dice2 inside {[1:6]}) begin
            m_sv = 1;
            ph = M_SHOW;
          end else begin
            m_err = 1;
            ph = M_SPIN;
            spin = 0;
          end
        end
        M_SHOW: case (craps(!m_pv, m_point, m_sum))
          0: ph = M_WON;
          1: ph = M_LOST;
          default: begin
            if (!m_pv) begin
              m_point = m_sum;
              m_pv = 1;
            end
            ph = M_WAIT;
          end
        endcase
        default: ph = M_WAIT;
      endcase
      db_last = db;
      if (syn[1] != db) begin
        run++;
        if (run == DEB) begin
          db = !db;
          run = 0;
        end
      end else run = 0;
      syn = {syn[0], btn};
    end
  end
  always @(negedge clk) if (chk_en) begin : cmp
    logic [14:0] act, exp;
    act = {bus.roll_en, bus.Press, bus.Win, bus.Loose, bus.sum_valid, bus.point_valid, bus.dice_err, bus.sum, bus.point};
    exp = {ph == M_SPIN, ph == M_WAIT, ph == M_WON, ph == M_LOST, m_sv, m_pv, m_err, 4'(m_sum), 4'(m_point)};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL outputs @%0t: got %h expected %h", $time, act, exp);
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    rolls += int'(bus.roll_en);
  endtask
  task automatic wait_roll();
    int n = 0;
    while (bus.roll_en !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("roll_start", bus.roll_en, 1);
  endtask
  task automatic wait_done();
    int n = 0;
    while ((bus.Press | bus.Win | bus.Loose) !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("settle", bus.Press | bus.Win | bus.Loose, 1);
  endtask
  task automatic play(logic [3:0] a, logic [3:0] b);
    bus.dice1 = a;
    bus.dice2 = b;
    btn = 1;
    repeat (6) @(negedge clk);
    btn = 0;
    wait_roll();
    wait_done();
  endtask
  task automatic bad_roll(logic [3:0] a);
    int n = 0;
    play(2, 4);
    chk("bad_pre_point", bus.point, 6);
    bus.dice1 = a;
    bus.dice2 = 3;
    btn = 1;
    repeat (6) @(negedge clk);
    btn = 0;
    while (bus.dice_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("err_pulse", bus.dice_err, 1);
    chk("err_reroll", bus.roll_en, 1);
    chk("err_point", bus.point, 6);
    chk("err_pv", bus.point_valid, 1);
    chk("err_sv", bus.sum_valid, 0);
    bus.dice1 = 3;
    bus.dice2 = 3;
    @(negedge clk);
    chk("err_one_cycle", bus.dice_err, 0);
    wait_done();
    chk("err_then_win", bus.Win, 1);
  endtask
  initial begin
    chk_en = 0;
    vectors = 0;
    miscompares = 0;
    rolls = 0;
    reset = 0;
    btn = 1;
    bus.dice1 = 3;
    bus.dice2 = 4;
    repeat (3) begin
      @(negedge clk);
      chk_en = 1;
      chk("reset_press", bus.Press, 1);
      chk("reset_quiet", {bus.roll_en, bus.Win, bus.Loose, bus.sum_valid, bus.point_valid, bus.dice_err, bus.sum, bus.point}, 0);
    end
    reset = 1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i >= 6) chk($sformatf("held_press_c%0d", i), bus.roll_en, i == 7);
    end
    btn = 0;
    wait_done();
    chk("co_3_4_win", bus.Win, 1);
    chk("co_3_4_sum", bus.sum, 7);
    chk("co_3_4_pv", bus.point_valid, 0);
    rolls = 0;
    repeat (3) begin
      btn = 1;
      repeat (2) step();
      btn = 0;
      repeat (3) step();
    end
    repeat (8) step();
    chk("glitch_no_roll", rolls, 0);
    chk("glitch_win_held", bus.Win, 1);
    bus.dice1 = 6;
    bus.dice2 = 5;
    rolls = 0;
    btn = 1;
    repeat (10) step();
    btn = 0;
    wait_done();
    chk("roll_len_10", rolls, 10);
    chk("co_6_5_win", bus.Win, 1);
    chk("co_6_5_sum", bus.sum, 11);
    play(1, 1);
    chk("co_1_1_lose", bus.Loose, 1);
    chk("co_1_1_sum", bus.sum, 2);
    play(1, 2);
    chk("co_1_2_lose", bus.Loose, 1);
    play(6, 6);
    chk("co_6_6_lose", bus.Loose, 1);
    chk("co_6_6_sum", bus.sum, 12);
    chk("co_6_6_win", bus.Win, 0);
    play(2, 4);
    chk("pt6_press", bus.Press, 1);
    chk("pt6_point", bus.point, 6);
    chk("pt6_pv", bus.point_valid, 1);
    play(3, 3);
    chk("pt6_hit_win", bus.Win, 1);
    play(2, 4);
    play(5, 4);
    chk("pt6_miss_press", bus.Press, 1);
    chk("pt6_miss_sum", bus.sum, 9);
    chk("pt6_miss_sv", bus.sum_valid, 1);
    play(3, 4);
    chk("pt6_seven_lose", bus.Loose, 1);
    chk("pt6_seven_nowin", bus.Win, 0);
    bad_roll(0);
    bad_roll(7);
    bus.dice1 = 3;
    bus.dice2 = 4;
    btn = 1;
    repeat (6) @(negedge clk);
    btn = 0;
    wait_roll();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_roll_press", bus.Press, 1);
    chk("rst_roll_en", bus.roll_en, 0);
    chk("rst_roll_wl", {bus.Win, bus.Loose}, 0);
    chk("rst_roll_pv", bus.point_valid, 0);
    reset = 1;
    play(2, 4);
    chk("pw_pv_before", bus.point_valid, 1);
    reset = 0;
    @(negedge clk);
    chk("rst_pw_pv", bus.point_valid, 0);
    chk("rst_pw_point", bus.point, 0);
    chk("rst_pw_press", bus.Press, 1);
    reset = 1;
    begin
      int hold = 0;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        bus.dice1 = rnd_face();
        bus.dice2 = rnd_face();
        reset = ($urandom_range(0, 599) != 0);
        if (hold == 0) begin
          btn = 1'($urandom_range(0, 1));
          hold = $urandom_range(1, 14);
        end
        hold--;
      end
    end
    reset = 1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
